// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EX-stage RV32I branch/jump resolution.
// Evaluates the branch condition, compares it with the fetch prediction and,
// on a misprediction, issues a one-cycle registered redirect plus a fixed
// two-cycle flush of IF/ID and ID/EX. Keeps saturating performance counters.
//
// Ports:
//   i_clk, i_reset            clock (rising edge), async active-low reset
//   i_br_valid, i_jump        branch present in EX / unconditional jump
//   i_funct3                  branch type (ignored for jumps)
//   i_rs1_data, i_rs2_data    resolved operands
//   i_pc, i_target            branch PC and precomputed taken target
//   i_pred_taken              fetch-stage prediction
//   o_redirect, o_redirect_pc registered redirect pulse and corrected PC
//   o_flush                   squash younger stages (two cycles)
//   o_illegal                 reserved funct3 pulse
//   o_br_count, o_mispred_count saturating counters
module branch_resolve_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_br_valid,
  input  logic             i_jump,
  input  logic [2:0]       i_funct3,
  input  logic [XLEN-1:0]  i_rs1_data,
  input  logic [XLEN-1:0]  i_rs2_data,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_target,
  input  logic             i_pred_taken,
  output logic             o_redirect,
  output logic [XLEN-1:0]  o_redirect_pc,
  output logic             o_flush,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_br_count,
  output logic [CNT_W-1:0] o_mispred_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH1 = 2'd1,
    FLUSH2 = 2'd2
  } stateE;

  stateE            state;
  stateE            nextState;
  logic             eq;
  logic             ltU;
  logic             ltS;
  logic             condTaken;
  logic             illegalF3;
  logic             taken;
  logic             accept;
  logic             mispred;
  logic             nextRedirect;
  logic [XLEN-1:0]  nextRedirectPc;
  logic             nextFlush;
  logic             nextIllegal;
  logic [CNT_W-1:0] nextBrCount;
  logic [CNT_W-1:0] nextMispredCount;

  // Branch condition evaluation
  always_comb begin
    eq        = (i_rs1_data == i_rs2_data);
    ltU       = (i_rs1_data < i_rs2_data);
    // Differing sign bits: the negative operand is the smaller one
    ltS       = (i_rs1_data[XLEN-1] != i_rs2_data[XLEN-1]) ? i_rs1_data[XLEN-1] : ltU;
    condTaken = 1'b0;
    illegalF3 = 1'b0;
    case (i_funct3)
      3'b000:  condTaken = eq;
      3'b001:  condTaken = !eq;
      3'b100:  condTaken = ltS;
      3'b101:  condTaken = !ltS;
      3'b110:  condTaken = ltU;
      3'b111:  condTaken = !ltU;
      default: illegalF3 = 1'b1;
    endcase
    taken = i_jump | condTaken;
  end

  // Next-state and next-output logic
  always_comb begin
    nextState        = state;
    nextRedirect     = 1'b0;
    nextRedirectPc   = o_redirect_pc;
    nextIllegal      = 1'b0;
    nextBrCount      = o_br_count;
    nextMispredCount = o_mispred_count;

    // Branches seen during a flush are wrong-path and dropped
    accept  = i_br_valid && (state == IDLE);
    mispred = accept && (taken ^ i_pred_taken);

    case (state)
      IDLE:    if (mispred) nextState = FLUSH1;
      FLUSH1:  nextState = FLUSH2;
      FLUSH2:  nextState = IDLE;
      default: nextState = IDLE;
    endcase

    if (mispred) begin
      nextRedirect   = 1'b1;
      nextRedirectPc = taken ? i_target : (i_pc + XLEN'(4));
    end
    nextIllegal = accept && !i_jump && illegalF3;

    if (accept && (o_br_count != {CNT_W{1'b1}}))
      nextBrCount = o_br_count + CNT_W'(1);
    if (mispred && (o_mispred_count != {CNT_W{1'b1}}))
      nextMispredCount = o_mispred_count + CNT_W'(1);

    nextFlush = (nextState != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state           <= IDLE;
      o_redirect      <= 1'b0;
      o_redirect_pc   <= '0;
      o_flush         <= 1'b0;
      o_illegal       <= 1'b0;
      o_br_count      <= '0;
      o_mispred_count <= '0;
    end else begin
      state           <= nextState;
      o_redirect      <= nextRedirect;
      o_redirect_pc   <= nextRedirectPc;
      o_flush         <= nextFlush;
      o_illegal       <= nextIllegal;
      o_br_count      <= nextBrCount;
      o_mispred_count <= nextMispredCount;
    end
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

EX-stage branch resolution for the non-forwarding RV32I pipeline. The unit accepts one resolved-operand branch or jump per cycle and evaluates the RV32I branch condition: equality, and signed or unsigned less-than. It compares the outcome against the fetch-stage prediction and, on a misprediction, issues a registered redirect and a fixed two-cycle flush of the younger pipeline stages. It also keeps saturating branch and misprediction counters for performance monitoring.

## Interface
Parameters:
- XLEN, 32, operand and PC width
- CNT_W, 16, width of each performance counter

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_br_valid  in  1  EX holds a branch or jump this cycle
- i_jump  in  1  unconditional (JAL/JALR); i_funct3 ignored
- i_funct3  in  3  000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
- i_rs1_data, i_rs2_data  in  XLEN  operands
- i_pc  in  XLEN  branch instruction PC
- i_target  in  XLEN  precomputed taken target
- i_pred_taken  in  1  prediction made at fetch
- o_redirect  out  1  one-cycle pulse: fetch must load o_redirect_pc
- o_redirect_pc  out  XLEN  corrected next PC
- o_flush  out  1  squash IF/ID and ID/EX
- o_illegal  out  1  one-cycle pulse: funct3 010/011 with i_br_valid and not i_jump
- o_br_count  out  CNT_W  accepted branches and jumps, saturating
- o_mispred_count  out  CNT_W  mispredictions, saturating

## Operation
- Condition evaluation:
  - eq = (rs1 == rs2).
  - lt_s = rs1 < rs2, two's-complement.
  - lt_u = rs1 < rs2, unsigned.
  - Signed case when the MSBs differ: rs1 negative means lt.
- taken:
  - i_jump → 1.
  - BEQ → eq; BNE → !eq.
  - BLT → lt_s; BGE → !lt_s.
  - BLTU → lt_u; BGEU → !lt_u.
  - funct3 010/011 → 0, and o_illegal pulses.
- Misprediction: mispred = taken XOR i_pred_taken.
- Redirect PC: taken ? i_target : i_pc + 4, modulo 2^XLEN (wraps at 0xFFFFFFFC → 0x00000000).
- FSM states:
  - IDLE:
    - An accepted branch with mispred → FLUSH1; o_redirect and o_redirect_pc register in the same edge.
    - Otherwise the FSM stays in IDLE.
  - FLUSH1: o_flush=1 → FLUSH2.
  - FLUSH2: o_flush=1 → IDLE.
- Acceptance: a branch is accepted only when i_br_valid=1 and the state is IDLE. In FLUSH1/FLUSH2, i_br_valid is wrong-path: it is ignored, not counted, and produces no redirect or o_illegal.
- Counters: each accepted branch increments o_br_count; each accepted mispred increments o_mispred_count. Both hold at all-ones.
- Correct prediction: no redirect, no flush, the counter update only.

## Timing
- Reset values (asynchronous, on i_reset=0): state IDLE, all outputs 0, o_redirect_pc=0, both counters 0.
- Latency: sample at edge N → o_redirect, o_redirect_pc and o_illegal valid during cycle N+1, for exactly one cycle.
- o_flush is high in cycles N+1 and N+2 (FLUSH1, FLUSH2), coincident with o_redirect in N+1.
- o_redirect_pc holds its last value between redirects.
- Back-to-back branches:
  - A mispredicted branch at edge N blocks acceptance at N+1 and N+2.
  - Acceptance resumes at N+3.
  - A correctly predicted branch at N does not block N+1.
- Counter increments appear in cycle N+1.
- Reset asserted mid-flush: immediate return to IDLE with o_flush=0. The first edge after release accepts normally.
- Simultaneous i_jump with an illegal funct3: treated as a jump, no o_illegal.

## Test plan
- Signed vs unsigned: rs1=0xFFFFFFFF, rs2=0x00000001, pred_taken=0.
  - BLT → taken, redirect to target, flush 2 cycles, mispred_count=1.
  - BLTU → not taken, no redirect.
- Equality: BEQ rs1=rs2=0x12345678, pred_taken=1 → no redirect, br_count +1, mispred_count unchanged. BNE with the same operands and pred_taken=1 → redirect to pc+4.
- Wrong-path suppression: mispredicted BGE at edge N. i_br_valid is held 1 with differing operands through N+2.
  - Only one redirect occurs; br_count increases by exactly 1 up to N+2.
  - A new branch is accepted at N+3.
- Wrap and illegal:
  - pc=0xFFFFFFFC, pred_taken=1, BEQ not taken → o_redirect_pc=0x00000000.
  - funct3=010 → o_illegal for one cycle, treated as not taken.
- Reset mid-flush and saturation:
  - Assert i_reset during FLUSH1 → o_flush drops immediately, counters read 0.
  - With CNT_W=4, 20 mispredicts → both counters stick at 0xF.
